// File: rtl/mist1032isa_uart_receiver.sv
// ---------------------------------------------------------------------------------------------
// mist1032isa_uart_receiver
//
// Single-clock 8N1 UART receiver (LSB first). It uses the same x4 baud-tick scheme and baudrate
// parameters as the companion transmitter, so both blocks can share one configuration.
//
// The pin is synchronised, a falling edge phase-aligns the tick generator, and the start bit is
// re-checked at its centre. Each data bit and the stop bit are then sampled at their nominal
// centres. A completed byte sits in a valid/acknowledge holding register. That register carries
// a framing-error flag and a sticky overrun flag.
//
// Parameters:
//   BAUDRATE_FIXED   - 1: tick limit comes from BAUDRATE_COUNTER, 0: from iEXTBAUD_COUNT
//   BAUDRATE_COUNTER - tick limit L = (clock / baudrate) / 4 - 1, at least 4
//
// Ports:
//   iCLOCK         in   system clock (only clock)
//   inRESET        in   asynchronous active-low reset
//   iEXTBAUD_COUNT in   external tick limit, stable while oRX_BUSY is high
//   iUART_RXD      in   asynchronous serial input, idle high
//   oRX_VALID      out  a received byte is held in oRX_DATA
//   oRX_DATA       out  received byte
//   oRX_FRAME_ERR  out  the held byte had a low stop bit
//   oRX_OVERRUN    out  sticky: a byte was dropped because the held one was not acknowledged
//   iRX_ACK        in   consumer acknowledge, ignored while oRX_VALID is low
//   oRX_BUSY       out  receive FSM is not idle
// ---------------------------------------------------------------------------------------------
module mist1032isa_uart_receiver #(
  parameter logic        BAUDRATE_FIXED   = 1'b1,
  parameter logic [19:0] BAUDRATE_COUNTER = 20'd108
) (
  input  logic        iCLOCK,
  input  logic        inRESET,
  input  logic [19:0] iEXTBAUD_COUNT,
  input  logic        iUART_RXD,
  output logic        oRX_VALID,
  output logic [7:0]  oRX_DATA,
  output logic        oRX_FRAME_ERR,
  output logic        oRX_OVERRUN,
  input  logic        iRX_ACK,
  output logic        oRX_BUSY
);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StWaitHigh
  } state_e;

  state_e      state_q;
  logic        rxd_meta_q;
  logic        rxd_s_q;
  logic [19:0] baud_cnt_q;
  logic [1:0]  sub_cnt_q;
  logic [2:0]  bit_idx_q;
  logic [7:0]  shift_q;
  logic        busy_q;
  logic        valid_q;
  logic [7:0]  data_q;
  logic        frame_err_q;
  logic        overrun_q;

  logic [19:0] baud_limit;
  logic        start_det;
  logic        tick;
  logic        byte_done;

  // -------------------------------------------------------------------------------------------
  // Tick generation
  // -------------------------------------------------------------------------------------------
  assign baud_limit = BAUDRATE_FIXED ? BAUDRATE_COUNTER : iEXTBAUD_COUNT;

  // A falling edge seen in IDLE restarts the tick phase, so no tick is issued in that cycle.
  assign start_det  = (state_q == StIdle) && !rxd_s_q;

  // Compare with >= so that a limit lowered at the wrong moment cannot make the counter run
  // through its whole 20-bit range before the next tick.
  assign tick       = !start_det && (baud_cnt_q >= baud_limit);

  // The stop bit is sampled on the 4th tick of the stop-bit period.
  assign byte_done  = (state_q == StStop) && tick && (sub_cnt_q == 2'd3);

  // -------------------------------------------------------------------------------------------
  // Two-flop synchroniser. Both flops reset to the idle (high) level, so reset release cannot
  // look like a start bit.
  // -------------------------------------------------------------------------------------------
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      rxd_meta_q <= 1'b1;
      rxd_s_q    <= 1'b1;
    end else begin
      rxd_meta_q <= iUART_RXD;
      rxd_s_q    <= rxd_meta_q;
    end
  end

  // -------------------------------------------------------------------------------------------
  // Baud tick counter, period L + 1 cycles
  // -------------------------------------------------------------------------------------------
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      baud_cnt_q <= 20'd0;
    end else if (start_det || tick) begin
      baud_cnt_q <= 20'd0;
    end else begin
      baud_cnt_q <= baud_cnt_q + 20'd1;
    end
  end

  // -------------------------------------------------------------------------------------------
  // Receive FSM
  //
  // The sub-counter counts ticks, with four ticks per bit. The start bit is re-checked on its
  // 2nd tick, which is the bit centre. From then on, every 4th tick falls on the centre of the
  // next bit.
  // -------------------------------------------------------------------------------------------
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      state_q   <= StIdle;
      busy_q    <= 1'b0;
      sub_cnt_q <= 2'd0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'h00;
    end else begin
      case (state_q)
        StIdle: begin
          if (!rxd_s_q) begin
            state_q   <= StStart;
            busy_q    <= 1'b1;
            sub_cnt_q <= 2'd0;
          end
        end

        StStart: begin
          if (tick) begin
            if (sub_cnt_q == 2'd1) begin
              if (!rxd_s_q) begin
                state_q   <= StData;
                bit_idx_q <= 3'd0;
                sub_cnt_q <= 2'd0;
              end else begin
                // The line went high again before mid-bit: treat it as a glitch.
                state_q <= StIdle;
                busy_q  <= 1'b0;
              end
            end else begin
              sub_cnt_q <= sub_cnt_q + 2'd1;
            end
          end
        end

        StData: begin
          if (tick) begin
            // The sub-counter wraps from 3 to 0, so STOP is entered with it at 0.
            sub_cnt_q <= sub_cnt_q + 2'd1;
            if (sub_cnt_q == 2'd3) begin
              shift_q   <= {rxd_s_q, shift_q[7:1]};
              bit_idx_q <= bit_idx_q + 3'd1;
              if (bit_idx_q == 3'd7) begin
                state_q <= StStop;
              end
            end
          end
        end

        StStop: begin
          if (tick) begin
            sub_cnt_q <= sub_cnt_q + 2'd1;
            if (sub_cnt_q == 2'd3) begin
              if (rxd_s_q) begin
                state_q <= StIdle;
                busy_q  <= 1'b0;
              end else begin
                state_q <= StWaitHigh;
              end
            end
          end
        end

        StWaitHigh: begin
          // A held-low line (break) must not be decoded as a stream of zero bytes.
          if (rxd_s_q) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end
        end

        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------------------------
  // Holding register
  //
  // A completion has priority over an acknowledge in the same cycle. The acknowledge frees the
  // slot, and the new byte fills it immediately. Data and frame error keep their last values
  // after an acknowledge.
  // -------------------------------------------------------------------------------------------
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      valid_q     <= 1'b0;
      data_q      <= 8'h00;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else if (byte_done) begin
      if (!valid_q || iRX_ACK) begin
        valid_q     <= 1'b1;
        data_q      <= shift_q;
        frame_err_q <= !rxd_s_q;
        if (iRX_ACK) begin
          overrun_q <= 1'b0;
        end
      end else begin
        overrun_q <= 1'b1;
      end
    end else if (iRX_ACK && valid_q) begin
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end
  end

  assign oRX_VALID     = valid_q;
  assign oRX_DATA      = data_q;
  assign oRX_FRAME_ERR = frame_err_q;
  assign oRX_OVERRUN   = overrun_q;
  assign oRX_BUSY      = busy_q;

endmodule

// File: doc/mist1032isa_uart_receiver.md
# mist1032isa_uart_receiver

Single-clock UART receiver, 8N1, LSB first, using the same x4 baud-tick convention and baudrate parameters as the team's UART transmitter, so the two blocks share configuration values. It synchronizes the asynchronous RXD pin, detects and validates the start bit, samples each bit at its nominal centre, and presents each byte through a held valid/acknowledge register with framing-error and overrun flags. It sits between the UART pin and the host-side peripheral register block.

## Interface

Parameters:
- BAUDRATE_FIXED, 1'b1: 0 selects iEXTBAUD_COUNT; 1 selects BAUDRATE_COUNTER.
- BAUDRATE_COUNTER, 20'd108: tick limit, equal to (Clock / Baudrate) / 4 - 1. Must be at least 20'h4.

Ports:
- iCLOCK, in, 1: system clock. This is the only clock.
- inRESET, in, 1: reset, asynchronous and active-low.
- iEXTBAUD_COUNT, in, 20: tick limit used when BAUDRATE_FIXED = 0. Must stay stable while oRX_BUSY = 1.
- iUART_RXD, in, 1: serial input. Asynchronous. Idle level is high.
- oRX_VALID, out, 1: received byte is held in oRX_DATA.
- oRX_DATA, out, 8: received byte.
- oRX_FRAME_ERR, out, 1: the held byte had a low stop bit.
- oRX_OVERRUN, out, 1: sticky; a byte was dropped.
- iRX_ACK, in, 1: consumer acknowledge. Ignored while oRX_VALID = 0.
- oRX_BUSY, out, 1: receive FSM is not in IDLE.

## Operation

- **Synchronizer:** iUART_RXD passes through 2 flops, each reset to 1. The output is rxd_s. All decisions use rxd_s only.
- **Tick generator:**
  - 20-bit counter, limit L = BAUDRATE_COUNTER or iEXTBAUD_COUNT.
  - When the counter equals L: tick = 1 for one cycle and the counter returns to 0. Otherwise the counter increments.
  - The tick period is P = L + 1 cycles.
  - In IDLE, when a start is detected, the counter is forced to 0 and no tick is issued. This phase-aligns sampling to the detected edge.
- **Sub-counter:** 2-bit sub-counter counts ticks. There are 4 ticks per bit.
- **FSM states** (oRX_BUSY = state != IDLE):
  - IDLE: rxd_s = 0 → START, sub-counter = 0.
  - START: counts ticks. On the 2nd tick (mid start bit):
    - rxd_s = 0 → DATA, bit index 0, sub-counter 0.
    - rxd_s = 1 → false start, back to IDLE, nothing reported.
  - DATA: on every 4th tick, shift rxd_s into bit [7] of the shift register (shift right) and increment the bit index. After bit index 7 is sampled → STOP.
  - STOP: on the 4th tick, sample the stop bit.
    - rxd_s = 1 → IDLE.
    - rxd_s = 0 → WAIT_HIGH.
    - In both cases, complete the byte with frame_err = !rxd_s.
  - WAIT_HIGH: stays until rxd_s = 1, then → IDLE. This prevents a held-low line (break) from being read as repeated starts.
- **Byte completion** (the cycle the stop bit is sampled):
  - If oRX_VALID = 0, or iRX_ACK = 1 in the same cycle: load oRX_DATA and oRX_FRAME_ERR; oRX_VALID = 1.
  - Otherwise (oRX_VALID = 1, no ack): the new byte is discarded, the held data and flags are unchanged, and oRX_OVERRUN is set to 1.
- **Acknowledge:**
  - iRX_ACK while oRX_VALID = 1, with no completion in the same cycle: oRX_VALID → 0 and oRX_OVERRUN → 0.
  - oRX_DATA and oRX_FRAME_ERR keep their last values.
  - When ack and completion coincide, the completion wins: valid stays 1 and the new data is loaded. oRX_OVERRUN is cleared in that case.

## Timing

- **Reset values:**
  - oRX_VALID = 0, oRX_DATA = 8'h00, oRX_FRAME_ERR = 0, oRX_OVERRUN = 0, oRX_BUSY = 0.
  - FSM = IDLE, both synchronizer flops = 1, counters = 0.
- **Reset during operation:** reset asserted during operation abandons the frame immediately. No partial byte is reported.
- **Pin to FSM:** 2 cycles from the pin to rxd_s. Start detection happens in the cycle after rxd_s goes low (cycle D).
- **Sampling points:**
  - Start check: D + 2P.
  - Data bit n (n = 0..7): D + (6 + 4n)P.
  - Stop bit: D + 38P.
- **Outputs:** oRX_VALID and the data appear on the cycle after the stop sample.
- **Busy:** oRX_BUSY goes high at D + 1 and drops on the cycle after the stop sample. For a stop error it stays high through WAIT_HIGH.
- **Back-to-back frames:** a new start is accepted in the first IDLE cycle. Back-to-back frames with a 1-bit stop are received without loss.
- **Baud tolerance:** ±2% baud mismatch is tolerated by centre sampling.

## Test plan

- **Nominal byte:** L = 4, send 0xA5 8N1 → oRX_DATA = 0xA5, oRX_VALID = 1 at D + 38P + 1, oRX_FRAME_ERR = 0, oRX_BUSY low on the same cycle.
- **Back-to-back with ack:** send 0x00 then 0xFF, ack each byte within one frame time → two valid bytes in order, oRX_OVERRUN = 0. Separately, ack exactly on the completion cycle → valid stays 1 and the new data is shown.
- **Overrun:** send 0x3C then 0xC3 with no ack → oRX_DATA = 0x3C, oRX_OVERRUN = 1. Then ack → oRX_VALID = 0, oRX_OVERRUN = 0.
- **Glitch and framing:**
  - Low glitch of P cycles on RXD → false start, no valid, FSM back in IDLE.
  - Stop bit forced low for 0x55 → oRX_DATA = 0x55, oRX_FRAME_ERR = 1, oRX_BUSY held until RXD returns high.
- **Break and reset:**
  - Hold RXD low for 20 bit times → exactly one byte 0x00 with frame error and no further bytes until RXD is high.
  - Assert inRESET mid-frame → all outputs at reset values, and the next clean frame 0x81 is received correctly.
- **External baud:** BAUDRATE_FIXED = 0, iEXTBAUD_COUNT = 9, send 0x7E → received correctly with sample points at multiples of P = 10.
